say_arbiter: RTL and testbench
==============================

SAY_ARBITER -- requirements
Module: say_arbiter

Interface
REQ-001 SHALL have parameter LAST_INIT, default 1, meaning the initial value of the last-granted pointer; with the default, port 0 wins the first tie.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port nRST, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have ports req0$say__ENA (in, 1), req0$say$meth (in, 6), req0$say$v (in, 4) and req0$say__RDY (out, 1): requester 0 say method.
REQ-005 SHALL have ports req1$say__ENA (in, 1), req1$say$meth (in, 6), req1$say$v (in, 4) and req1$say__RDY (out, 1): requester 1 say method.
REQ-006 SHALL have ports ind$heard__ENA (out, 1), ind$heard$meth (out, 6), ind$heard$v (out, 4), ind$heard$src (out, 1) and ind$heard__RDY (in, 1): the shared indication path; src is the index of the granted requester.
REQ-007 SHALL have ports count0 (out, 16) and count1 (out, 16): per-requester grant counters.

Function
REQ-008 SHALL hold one 10-bit entry {meth, v} per requester in a one-entry buffer.
REQ-009 reqN$say__RDY SHALL equal NOT fullN; a say is accepted only in a cycle where ENA and RDY are both high.
REQ-010 An accepted say SHALL set fullN and capture {meth, v} at the next edge; ENA asserted while RDY is low is ignored.
REQ-011 Grant selection SHALL be combinational:
- exactly one buffer full: grant that buffer;
- both full: grant the port other than the last-granted pointer;
- neither full: no grant.
REQ-012 ind$heard__ENA SHALL equal (full0 OR full1) AND ind$heard__RDY.
REQ-013 meth, v and src SHALL present the granted entry whenever a grant exists, regardless of RDY.
REQ-014 In a cycle with ind$heard__ENA high, the arbiter SHALL:
- clear the granted buffer's full bit;
- set the last-granted pointer to src;
- increment that port's count by 1, modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-015 Latency SHALL be one cycle: a say accepted in cycle N appears on ind$heard no earlier than cycle N+1. There is no bypass.
REQ-016 Sustained throughput SHALL be one say per requester every 2 cycles, and one indication per cycle overall.
REQ-017 When ind$heard__RDY is low, both buffers, the pointer and the counters SHALL hold.
REQ-018 Simultaneous enq on both ports SHALL be accepted in the same cycle; the grant order then follows REQ-011.
REQ-019 The pointer SHALL change only on a delivered indication; a lone requester does not lose priority bookkeeping.

Reset
REQ-020 When nRST is low, the following SHALL be cleared immediately, without waiting for CLK:
- full0 and full1 to 0;
- the pointer to LAST_INIT;
- count0 and count1 to 0;
- buffer data to 0.
REQ-021 During reset, the outputs SHALL be: ind$heard__ENA 0, meth/v/src 0, req0$say__RDY 1, req1$say__RDY 1.
REQ-022 Reset asserted mid-operation SHALL discard buffered entries without emitting them.
REQ-023 After release, the first edge SHALL accept a new say.

Structure
REQ-024 A shared package SHALL define:
- typedef say_msg_t {meth[5:0], v[3:0]};
- constants SAY_METH_W = 6, SAY_V_W = 4, SAY_MSG_W = 10, CNT_W = 16.
REQ-025 SHALL instantiate the one-entry buffer sub-module say_fifo1 (enq/deq/first with RDY, asynchronous active-low reset) once per requester.
REQ-026 Grant logic, pointer and counters SHALL live in say_arbiter itself.

Verification
REQ-027 Single requester: req0 says meth=0x2A, v=0x5 with ind RDY=1 -> cycle N+1: ENA=1, meth=0x2A, v=0x5, src=0; count0=1; req0 RDY low in N+1, high again in N+2.
REQ-028 Tie: both say in the same cycle after reset (LAST_INIT=1), req0 {0x01, 0x1}, req1 {0x02, 0x2} -> src=0 with 0x01 first, then src=1 with 0x02 next cycle; counts 1/1.
REQ-029 Backpressure: both buffers full, ind RDY=0 for 5 cycles -> ENA=0, outputs stable on src=0 data, both say RDY low, counts unchanged; RDY=1 -> drains in 2 cycles.
REQ-030 Saturation: both ports say every cycle that RDY allows, for 200 cycles -> grants alternate 0,1,0,1..., ind ENA high every cycle after fill, |count0 - count1| <= 1.
REQ-031 Wrap: 65536 grants on port 0 -> count0 returns to 0x0000; count1 unaffected.
REQ-032 Async reset: assert nRST mid-cycle with both buffers full -> ENA drops before the next edge, counts = 0, both say RDY = 1; no stale entry emitted after release.

Source files
------------

// File: rtl/say_arbiter_pkg.sv
// rtl/say_arbiter_pkg.sv - shared widths, message type and grant helper for the say arbiter
package say_arbiter_pkg;

    localparam int SAY_METH_W = 6;
    localparam int SAY_V_W    = 4;
    localparam int SAY_MSG_W  = 10;
    localparam int CNT_W      = 16;

    typedef struct packed {
        logic [SAY_METH_W-1:0] meth;
        logic [SAY_V_W-1:0]    v;
    } say_msg_t;

    // Winning port index; on a tie the port that did not win last time goes first.
    function automatic logic pick_src(input logic full0, input logic full1, input logic last);
        return (full0 && full1) ? ~last : full1;
    endfunction

endpackage

// File: rtl/say_fifo1.sv
// rtl/say_fifo1.sv - one-entry say buffer; enq only when empty, deq only when full
module say_fifo1
    import say_arbiter_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     enq_ena_i,
    input  say_msg_t enq_msg_i,
    output logic     enq_rdy_o,
    input  logic     deq_ena_i,
    output logic     deq_rdy_o,
    output say_msg_t first_o
);

    logic     full_q, full_d;
    say_msg_t data_q, data_d;

    assign enq_rdy_o = ~full_q;
    assign deq_rdy_o = full_q;
    assign first_o   = data_q;

    // Enq and deq are mutually exclusive by the full flag, so no bypass path exists.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (enq_ena_i && !full_q) begin
            full_d = 1'b1;
            data_d = enq_msg_i;
        end else if (deq_ena_i && full_q) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/say_arbiter.sv
// rtl/say_arbiter.sv - two-requester round-robin arbiter onto one heard indication path
module say_arbiter
    import say_arbiter_pkg::*;
#(
    parameter bit LAST_INIT = 1'b1
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  req0_say__ENA,
    input  logic [SAY_METH_W-1:0] req0_say_meth,
    input  logic [SAY_V_W-1:0]    req0_say_v,
    output logic                  req0_say__RDY,
    input  logic                  req1_say__ENA,
    input  logic [SAY_METH_W-1:0] req1_say_meth,
    input  logic [SAY_V_W-1:0]    req1_say_v,
    output logic                  req1_say__RDY,
    output logic                  ind_heard__ENA,
    output logic [SAY_METH_W-1:0] ind_heard_meth,
    output logic [SAY_V_W-1:0]    ind_heard_v,
    output logic                  ind_heard_src,
    input  logic                  ind_heard__RDY,
    output logic [CNT_W-1:0]      count0,
    output logic [CNT_W-1:0]      count1
);

    logic             full0, full1;
    logic             deq0, deq1;
    say_msg_t         first0, first1;
    say_msg_t         grant_msg;
    logic             has_grant, grant_src, deliver;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    say_fifo1 u_fifo0 (
        .clk_i     (CLK),
        .rst_ni    (nRST),
        .enq_ena_i (req0_say__ENA),
        .enq_msg_i ({req0_say_meth, req0_say_v}),
        .enq_rdy_o (req0_say__RDY),
        .deq_ena_i (deq0),
        .deq_rdy_o (full0),
        .first_o   (first0)
    );

    say_fifo1 u_fifo1 (
        .clk_i     (CLK),
        .rst_ni    (nRST),
        .enq_ena_i (req1_say__ENA),
        .enq_msg_i ({req1_say_meth, req1_say_v}),
        .enq_rdy_o (req1_say__RDY),
        .deq_ena_i (deq1),
        .deq_rdy_o (full1),
        .first_o   (first1)
    );

    assign has_grant = full0 | full1;
    assign grant_src = pick_src(full0, full1, last_q);
    assign deliver   = has_grant & ind_heard__RDY;
    assign deq0      = deliver & ~grant_src;
    assign deq1      = deliver & grant_src;

    // Data path shows the granted entry even while the consumer stalls; zero when idle.
    always_comb begin
        grant_msg = '0;
        if (has_grant) begin
            grant_msg = grant_src ? first1 : first0;
        end
    end

    assign ind_heard__ENA = deliver;
    assign ind_heard_meth = grant_msg.meth;
    assign ind_heard_v    = grant_msg.v;
    assign ind_heard_src  = has_grant & grant_src;
    assign count0         = cnt0_q;
    assign count1         = cnt1_q;

    always_comb begin
        last_d = last_q;
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (deliver) begin
            last_d = grant_src;
            if (grant_src) begin
                cnt1_d = cnt1_q + 1'b1;
            end else begin
                cnt0_d = cnt0_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_q <= LAST_INIT;
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (deliver) begin
            last_q <= last_d;
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

endmodule

// File: tb/tb_say_arbiter.sv
// tb/tb_say_arbiter.sv - directed vector bench for say_arbiter
module tb_say_arbiter;
    import say_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r0_ena = 1'b0, r1_ena = 1'b0, ind_rdy = 1'b1;
    logic [5:0]  r0_meth = '0, r1_meth = '0;
    logic [3:0]  r0_v = '0, r1_v = '0;
    logic        r0_rdy, r1_rdy, ind_ena, ind_src;
    logic [5:0]  ind_meth;
    logic [3:0]  ind_v;
    logic [15:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    say_arbiter #(.LAST_INIT(1'b1)) dut (
        .CLK            (clk),
        .nRST           (rst_n),
        .req0_say__ENA  (r0_ena),
        .req0_say_meth  (r0_meth),
        .req0_say_v     (r0_v),
        .req0_say__RDY  (r0_rdy),
        .req1_say__ENA  (r1_ena),
        .req1_say_meth  (r1_meth),
        .req1_say_v     (r1_v),
        .req1_say__RDY  (r1_rdy),
        .ind_heard__ENA (ind_ena),
        .ind_heard_meth (ind_meth),
        .ind_heard_v    (ind_v),
        .ind_heard_src  (ind_src),
        .ind_heard__RDY (ind_rdy),
        .count0         (cnt0),
        .count1         (cnt1)
    );

    typedef struct {
        logic        e0;
        logic [5:0]  m0;
        logic [3:0]  v0;
        logic        e1;
        logic [5:0]  m1;
        logic [3:0]  v1;
        logic        rdy;
        logic        x_ena;
        logic [5:0]  x_meth;
        logic [3:0]  x_v;
        logic        x_src;
        logic        x_rdy0;
        logic        x_rdy1;
        logic [15:0] x_c0;
        logic [15:0] x_c1;
    } vec_t;

    vec_t tbl[$];

    // Reference state for the longer sequences.
    logic        mf0, mf1, ml;
    logic [15:0] mc0, mc1;
    logic [9:0]  md0, md1;

    function automatic vec_t mk(input logic e0, input logic [5:0] m0, input logic [3:0] v0,
                                input logic e1, input logic [5:0] m1, input logic [3:0] v1,
                                input logic rdy, input logic xe, input logic [5:0] xm,
                                input logic [3:0] xv, input logic xs, input logic xr0,
                                input logic xr1, input logic [15:0] xc0, input logic [15:0] xc1);
        vec_t r;
        r.e0 = e0; r.m0 = m0; r.v0 = v0; r.e1 = e1; r.m1 = m1; r.v1 = v1; r.rdy = rdy;
        r.x_ena = xe; r.x_meth = xm; r.x_v = xv; r.x_src = xs;
        r.x_rdy0 = xr0; r.x_rdy1 = xr1; r.x_c0 = xc0; r.x_c1 = xc1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic e0, input logic [5:0] m0, input logic [3:0] v0,
                         input logic e1, input logic [5:0] m1, input logic [3:0] v1,
                         input logic rdy);
        @(negedge clk);
        r0_ena = e0; r0_meth = m0; r0_v = v0;
        r1_ena = e1; r1_meth = m1; r1_v = v1;
        ind_rdy = rdy;
        #2;
    endtask

    task automatic check_out(input string tag, input logic xe, input logic [5:0] xm,
                             input logic [3:0] xv, input logic xs, input logic xr0,
                             input logic xr1, input logic [15:0] xc0, input logic [15:0] xc1);
        chk({tag, ".ena"},  32'(ind_ena),  32'(xe));
        chk({tag, ".meth"}, 32'(ind_meth), 32'(xm));
        chk({tag, ".v"},    32'(ind_v),    32'(xv));
        chk({tag, ".src"},  32'(ind_src),  32'(xs));
        chk({tag, ".rdy0"}, 32'(r0_rdy),   32'(xr0));
        chk({tag, ".rdy1"}, 32'(r1_rdy),   32'(xr1));
        chk({tag, ".cnt0"}, 32'(cnt0),     32'(xc0));
        chk({tag, ".cnt1"}, 32'(cnt1),     32'(xc1));
    endtask

    // One cycle checked against the reference state, which then steps past the edge.
    task automatic mcycle(input string tag, input logic e0, input logic [5:0] m0,
                          input logic [3:0] v0, input logic e1, input logic [5:0] m1,
                          input logic [3:0] v1, input logic rdy);
        logic       any, src, del;
        logic [9:0] d;
        apply(e0, m0, v0, e1, m1, v1, rdy);
        any = mf0 | mf1;
        src = (mf0 && mf1) ? !ml : mf1;
        d   = any ? (src ? md1 : md0) : 10'h000;
        del = any & rdy;
        check_out(tag, del, d[9:4], d[3:0], any & src, !mf0, !mf1, mc0, mc1);
        if (del) begin
            ml = src;
            if (src) begin mf1 = 1'b0; mc1 = mc1 + 16'd1; end
            else     begin mf0 = 1'b0; mc0 = mc0 + 16'd1; end
        end
        if (e0 && r0_rdy && !mf0 && !(del && !src)) begin mf0 = 1'b1; md0 = {m0, v0}; end
        if (e1 && r1_rdy && !mf1 && !(del && src))  begin mf1 = 1'b1; md1 = {m1, v1}; end
    endtask

    initial begin
        tbl.push_back(mk(0,6'h00,4'h0, 0,6'h00,4'h0, 1, 0,6'h00,4'h0,0, 1,1, 16'd0,16'd0));
        tbl.push_back(mk(1,6'h01,4'h1, 1,6'h02,4'h2, 1, 0,6'h00,4'h0,0, 1,1, 16'd0,16'd0));
        tbl.push_back(mk(0,6'h00,4'h0, 0,6'h00,4'h0, 1, 1,6'h01,4'h1,0, 0,0, 16'd0,16'd0));
        tbl.push_back(mk(0,6'h00,4'h0, 0,6'h00,4'h0, 1, 1,6'h02,4'h2,1, 1,0, 16'd1,16'd0));
        tbl.push_back(mk(1,6'h2A,4'h5, 0,6'h00,4'h0, 1, 0,6'h00,4'h0,0, 1,1, 16'd1,16'd1));
        tbl.push_back(mk(0,6'h00,4'h0, 0,6'h00,4'h0, 1, 1,6'h2A,4'h5,0, 0,1, 16'd1,16'd1));
        tbl.push_back(mk(0,6'h00,4'h0, 1,6'h3F,4'hF, 1, 0,6'h00,4'h0,0, 1,1, 16'd2,16'd1));
        tbl.push_back(mk(0,6'h00,4'h0, 0,6'h00,4'h0, 1, 1,6'h3F,4'hF,1, 1,0, 16'd2,16'd1));
        tbl.push_back(mk(1,6'h11,4'h3, 1,6'h22,4'h4, 0, 0,6'h00,4'h0,0, 1,1, 16'd2,16'd2));
        tbl.push_back(mk(0,6'h00,4'h0, 0,6'h00,4'h0, 0, 0,6'h11,4'h3,0, 0,0, 16'd2,16'd2));
        tbl.push_back(mk(1,6'h15,4'h7, 1,6'h16,4'h8, 0, 0,6'h11,4'h3,0, 0,0, 16'd2,16'd2));
        tbl.push_back(mk(0,6'h00,4'h0, 0,6'h00,4'h0, 0, 0,6'h11,4'h3,0, 0,0, 16'd2,16'd2));
        tbl.push_back(mk(0,6'h00,4'h0, 0,6'h00,4'h0, 0, 0,6'h11,4'h3,0, 0,0, 16'd2,16'd2));
        tbl.push_back(mk(0,6'h00,4'h0, 0,6'h00,4'h0, 0, 0,6'h11,4'h3,0, 0,0, 16'd2,16'd2));
        tbl.push_back(mk(0,6'h00,4'h0, 0,6'h00,4'h0, 1, 1,6'h11,4'h3,0, 0,0, 16'd2,16'd2));
        tbl.push_back(mk(0,6'h00,4'h0, 0,6'h00,4'h0, 1, 1,6'h22,4'h4,1, 1,0, 16'd3,16'd2));
        tbl.push_back(mk(0,6'h00,4'h0, 0,6'h00,4'h0, 1, 0,6'h00,4'h0,0, 1,1, 16'd3,16'd3));

        // Reset state, with a say offered that must not be taken.
        r0_ena = 1'b1; r0_meth = 6'h3C; r0_v = 4'hA; ind_rdy = 1'b1;
        #2;
        check_out("reset", 0, 6'h00, 4'h0, 0, 1, 1, 16'd0, 16'd0);
        @(negedge clk);
        r0_ena = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].e0, tbl[i].m0, tbl[i].v0, tbl[i].e1, tbl[i].m1, tbl[i].v1, tbl[i].rdy);
            check_out($sformatf("vec%0d", i), tbl[i].x_ena, tbl[i].x_meth, tbl[i].x_v,
                      tbl[i].x_src, tbl[i].x_rdy0, tbl[i].x_rdy1, tbl[i].x_c0, tbl[i].x_c1);
        end

        mf0 = 1'b0; mf1 = 1'b0; ml = 1'b1; mc0 = 16'd3; mc1 = 16'd3;
        md0 = '0; md1 = '0;

        // Saturation: both ports offer every cycle; grants must alternate once filled.
        for (int c = 0; c < 200; c++) begin
            logic [7:0] cc;
            int         diff;
            cc = 8'(c);
            mcycle("sat", 1'b1, cc[5:0], cc[3:0], 1'b1, ~cc[5:0], ~cc[3:0], 1'b1);
            if (c >= 1) begin
                chk("sat_ena_every_cycle", 32'(ind_ena), 32'd1);
                chk("sat_alternate", 32'(ind_src), (c % 2 == 0) ? 32'd1 : 32'd0);
            end
            diff = int'(cnt0) - int'(cnt1);
            chk("sat_balance", (diff <= 1 && diff >= -1) ? 32'd1 : 32'd0, 32'd1);
        end
        for (int c = 0; c < 3; c++) begin
            mcycle("drain", 0, 6'h00, 4'h0, 0, 6'h00, 4'h0, 1);
        end

        // Counter wrap: preload near the top, then deliver two port-0 says.
        @(negedge clk);
        force dut.cnt0_q = 16'hFFFE;
        #1;
        release dut.cnt0_q;
        mc0 = 16'hFFFE;
        mcycle("wrap_a", 1, 6'h05, 4'h1, 0, 6'h00, 4'h0, 1);
        mcycle("wrap_b", 0, 6'h00, 4'h0, 0, 6'h00, 4'h0, 1);
        mcycle("wrap_c", 1, 6'h06, 4'h2, 0, 6'h00, 4'h0, 1);
        mcycle("wrap_d", 0, 6'h00, 4'h0, 0, 6'h00, 4'h0, 1);
        mcycle("wrap_e", 0, 6'h00, 4'h0, 0, 6'h00, 4'h0, 1);
        chk("wrap_cnt0_zero", 32'(cnt0), 32'h0000);
        chk("wrap_cnt1_kept", 32'(cnt1), 32'(mc1));

        // Asynchronous reset with both buffers full.
        mcycle("pre_rst_a", 1, 6'h2D, 4'h6, 1, 6'h1E, 4'h9, 0);
        mcycle("pre_rst_b", 0, 6'h00, 4'h0, 0, 6'h00, 4'h0, 0);
        @(negedge clk);
        ind_rdy = 1'b1;
        #1;
        chk("pre_rst_ena", 32'(ind_ena), 32'd1);
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 0, 6'h00, 4'h0, 0, 1, 1, 16'd0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        r0_ena = 1'b1; r0_meth = 6'h0C; r0_v = 4'h9;
        #2;
        check_out("post_rst_0", 0, 6'h00, 4'h0, 0, 1, 1, 16'd0, 16'd0);
        apply(0, 6'h00, 4'h0, 0, 6'h00, 4'h0, 1);
        check_out("post_rst_1", 1, 6'h0C, 4'h9, 0, 0, 1, 16'd0, 16'd0);
        apply(0, 6'h00, 4'h0, 0, 6'h00, 4'h0, 1);
        check_out("post_rst_2", 0, 6'h00, 4'h0, 0, 1, 1, 16'd1, 16'd0);
        apply(0, 6'h00, 4'h0, 0, 6'h00, 4'h0, 1);
        check_out("post_rst_3", 0, 6'h00, 4'h0, 0, 1, 1, 16'd1, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
